// File: rtl/cp0_pkg.sv
// Shared constants and field helpers for the P7 coprocessor-0 block.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LO      = 10;
  localparam int SR_IM_HI      = 15;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_EXC_HI  = 6;
  localparam int CAUSE_IP_LO   = 10;
  localparam int CAUSE_IP_HI   = 15;
  localparam int CAUSE_BD_BIT  = 31;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] PRID_DEF       = 32'h4255_4141;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  function automatic logic [31:0] sr_pack(input sr_t s);
    logic [31:0] r;
    r = 32'h0000_0000;
    r[SR_IM_HI:SR_IM_LO] = s.im;
    r[SR_EXL_BIT]        = s.exl;
    r[SR_IE_BIT]         = s.ie;
    return r;
  endfunction

  function automatic logic [31:0] cause_pack(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] r;
    r = 32'h0000_0000;
    r[CAUSE_BD_BIT]                 = bd;
    r[CAUSE_IP_HI:CAUSE_IP_LO]      = ip;
    r[CAUSE_EXC_HI:CAUSE_EXC_LO]    = exc;
    return r;
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Combinational interrupt/exception arbitration: interrupts win and record ExcCode 0.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic [5:0] hwint_i,
  input  logic [5:0] im_i,
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic [4:0] exc_code_i,
  output logic       int_req_o,
  output logic       exc_req_o,
  output logic       req_o,
  output logic [4:0] exc_code_o
);

  // Raw requests, both suppressed while a handler is active
  always_comb begin
    int_req_o  = (|(hwint_i & im_i)) & ie_i & ~exl_i;
    exc_req_o  = (exc_code_i != EXC_INT) & ~exl_i;
    req_o      = int_req_o | exc_req_o;
    if (int_req_o) begin
      exc_code_o = EXC_INT;
    end else begin
      exc_code_o = exc_code_i;
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 (SR, Cause, EPC, PRId) for the P7 pipeline.
// Optional BadVAddr register (index 8) enabled by defining CP0_BADVADDR_EN.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = PRID_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] BadAddrIn,
`endif
  output logic        IntReq,
  output logic [31:0] EPCOut,
  output logic [31:0] Dout,
  output logic [31:0] HandlerPC
);

  sr_t         sr_q, sr_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic        int_req_s, exc_req_s, req_s;
  logic [4:0]  exc_sel_s;

  cp0_req_arb u_arb (
    .hwint_i    (HWInt),
    .im_i       (sr_q.im),
    .ie_i       (sr_q.ie),
    .exl_i      (sr_q.exl),
    .exc_code_i (ExcCodeIn),
    .int_req_o  (int_req_s),
    .exc_req_o  (exc_req_s),
    .req_o      (req_s),
    .exc_code_o (exc_sel_s)
  );

`ifdef CP0_BADVADDR_EN
  logic [31:0] bva_q, bva_d;

  // BadVAddr captures the faulting address only for a taken AdEL/AdES
  always_comb begin
    bva_d = bva_q;
    if (req_s && exc_req_s && !int_req_s &&
        (ExcCodeIn == EXC_ADEL || ExcCodeIn == EXC_ADES)) begin
      bva_d = BadAddrIn;
    end else begin
      bva_d = bva_q;
    end
  end

  // BadVAddr register
  always_ff @(posedge clk) begin
    if (reset) begin
      bva_q <= 32'h0000_0000;
    end else begin
      bva_q <= bva_d;
    end
  end
`endif

  // Next-state: a taken request flushes the M-stage mtc0, so it wins over WE
  always_comb begin
    sr_d      = sr_q;
    bd_d      = bd_q;
    ip_d      = HWInt;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    if (req_s) begin
      sr_d.exl  = 1'b1;
      exccode_d = exc_sel_s;
      bd_d      = BDIn;
      if (BDIn) begin
        epc_d = (PC & 32'hFFFF_FFFC) - 32'd4;
      end else begin
        epc_d = PC & 32'hFFFF_FFFC;
      end
    end else begin
      if (WE) begin
        case (A2)
          REG_SR: begin
            sr_d.im  = Din[SR_IM_HI:SR_IM_LO];
            sr_d.exl = Din[SR_EXL_BIT];
            sr_d.ie  = Din[SR_IE_BIT];
          end
          REG_EPC: epc_d = Din & 32'hFFFF_FFFC;
          default: epc_d = epc_q;
        endcase
      end else begin
        sr_d = sr_q;
      end
      if (EXLClr) begin
        sr_d.exl = 1'b0;
      end else begin
        sr_d.exl = sr_d.exl;
      end
    end
  end

  // SR/Cause/EPC state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'h0000_0000;
    end else begin
      sr_q      <= sr_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  // mfc0 read port, no bypass from a same-cycle mtc0
  always_comb begin
    case (A1)
      REG_SR:       Dout = sr_pack(sr_q);
      REG_CAUSE:    Dout = cause_pack(bd_q, ip_q, exccode_q);
      REG_EPC:      Dout = epc_q;
      REG_PRID:     Dout = PRID_VAL;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: Dout = bva_q;
`endif
      default:      Dout = 32'h0000_0000;
    endcase
  end

  assign IntReq    = req_s;
  assign EPCOut    = epc_q;
  assign HandlerPC = EXC_VECTOR;

endmodule
